// File: rtl/reg_file_ab_pkg.sv
// Shared CPU constants for the register file, control FSM and register-destination mux.
// Also holds the write-to-read bypass predicate used by both operand latches.
package reg_file_ab_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // True when a write landing this edge targets the given source index.
  // Writes to the zero register never forward.
  function automatic logic bypass_sel(input reg_idx_t idx, input logic wr_en,
                                      input reg_idx_t wr_idx);
    return wr_en && (wr_idx != REG_ZERO) && (wr_idx == idx);
  endfunction

endpackage

// File: rtl/reg_file_ab.sv
// 2^ADDR_W x DATA_W register file with three combinational read ports (two operand, one debug)
// and the A/B operand latches that forward a same-edge write-back.
module reg_file_ab
  import reg_file_ab_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] A_reg,
  output logic [DATA_W-1:0] B_reg,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 is reset but never written; the read muxes also force it to zero
  // so it reads correctly even before the first reset.
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              wr_valid;

  assign wr_valid = RegWrite && (write_reg != REG_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_valid) begin
      mem_reg[write_reg] <= write_data;
    end
  end

  // Port 0 -> read_reg1/A, port 1 -> read_reg2/B, port 2 -> debug.
  logic [ADDR_W-1:0] rd_idx [3];
  logic [DATA_W-1:0] rd_val [3];
  logic [DATA_W-1:0] lat_next [2];
  logic [DATA_W-1:0] lat_reg [2];

  assign rd_idx[0] = read_reg1;
  assign rd_idx[1] = read_reg2;
  assign rd_idx[2] = dbg_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_val[gi] = (rd_idx[gi] == REG_ZERO) ? '0 : mem_reg[rd_idx[gi]];
    end
    for (gi = 0; gi < 2; gi++) begin : g_lat
      // rd_val already forces index 0 to zero, and bypass_sel never fires for it.
      assign lat_next[gi] = bypass_sel(rd_idx[gi], RegWrite, write_reg) ? write_data
                                                                        : rd_val[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) lat_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) lat_reg[i] <= lat_next[i];
    end
  end

  assign read_data1 = rd_val[0];
  assign read_data2 = rd_val[1];
  assign dbg_data   = rd_val[2];
  assign A_reg      = lat_reg[0];
  assign B_reg      = lat_reg[1];

endmodule

// File: tb/tb_reg_file_ab.sv
// Self-checking bench for reg_file_ab: behavioural array model, per-cycle compare process,
// directed literal checks and randomized traffic with occasional asynchronous reset pulses.
module tb_reg_file_ab;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [4:0]  dbg_sel = '0;
  logic [31:0] read_data1, read_data2, A_reg, B_reg, dbg_data;

  reg_file_ab #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .A_reg(A_reg), .B_reg(B_reg),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  // Behavioural model: plain array of register contents plus expected operand latches.
  logic [31:0] model [32];
  logic [31:0] a_exp = '0;
  logic [31:0] b_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    a_exp = '0;
    b_exp = '0;
  endtask

  // One transaction: present inputs, take one rising edge, advance the model, return at edge+2.
  task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dsel);
    RegWrite = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; dbg_sel = dsel;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      a_exp = (r1 != 0 && we && wr == r1) ? wd : model_rd(r1);
      b_exp = (r2 != 0 && we && wr == r2) ? wd : model_rd(r2);
      if (we && wr != 0) model[wr] = wd;
    end
    $display("[TB] txn we=%0d wr=%0d wd=%08h r1=%0d r2=%0d dbg=%0d rst=%0d",
             we, wr, wd, r1, r2, dsel, rst);
    #2;
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_read_data1", read_data1, model_rd(read_reg1));
      chk("cmp_read_data2", read_data2, model_rd(read_reg2));
      chk("cmp_dbg_data",   dbg_data,   model_rd(dbg_sel));
      chk("cmp_A_reg",      A_reg,      a_exp);
      chk("cmp_B_reg",      B_reg,      b_exp);
    end
  end

  initial begin
    model_clear();
    // Reset with arbitrary inputs.
    #1;
    RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'hCAFEF00D;
    read_reg1 = 5'd4; read_reg2 = 5'd4; dbg_sel = 5'd4;
    rst = 1'b1;
    #2;
    chk("rst_A_reg", A_reg, 32'h0);
    chk("rst_B_reg", B_reg, 32'h0);
    chk("rst_read_data1", read_data1, 32'h0);
    chk("rst_read_data2", read_data2, 32'h0);
    chk("rst_dbg_data", dbg_data, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    RegWrite = 1'b0;
    cmp_en = 1'b1;

    for (int i = 1; i < 32; i++) begin
      read_reg1 = 5'(i);
      #0.1;
      chk("post_rst_zero", read_data1, 32'h0);
    end

    // Basic write/read.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd5);
    read_reg1 = 5'd5;
    #1;
    chk("basic_read_data1", read_data1, 32'hDEADBEEF);
    chk("basic_dbg_data", dbg_data, 32'hDEADBEEF);
    chk("basic_A_before", A_reg, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
    chk("basic_A_reg", A_reg, 32'hDEADBEEF);

    // Zero register: write discarded, source 0 latches 0 even during that write.
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
    chk("zero_A_same_cycle", A_reg, 32'h0);
    chk("zero_read_data1", read_data1, 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("zero_A_reg", A_reg, 32'h0);

    // Bypass on both latches.
    cycle(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 5'd0);
    cycle(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
    chk("bypass_A_reg", A_reg, 32'h22);
    chk("bypass_B_reg", B_reg, 32'h22);
    chk("bypass_read_data1", read_data1, 32'h22);
    cycle(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
    chk("nobypass_A_reg", A_reg, 32'h11);

    // Write disable.
    cycle(1'b0, 5'd9, 32'h0000FFFF, 5'd9, 5'd9, 5'd9);
    chk("wr_dis_read_data1", read_data1, 32'h0);
    chk("wr_dis_dbg_data", dbg_data, 32'h0);

    // Asynchronous reset between edges; the write in the reset cycle is lost.
    cycle(1'b1, 5'd3, 32'hAA, 5'd3, 5'd3, 5'd3);
    chk("pre_rst_read_data1", read_data1, 32'hAA);
    chk("pre_rst_A_reg", A_reg, 32'hAA);
    rst = 1'b1;
    model_clear();
    #1;
    chk("async_rst_read_data1", read_data1, 32'h0);
    chk("async_rst_A_reg", A_reg, 32'h0);
    cycle(1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 5'd3);
    rst = 1'b0;
    cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    chk("rst_write_lost", read_data1, 32'h0);
    chk("rst_write_lost_A", A_reg, 32'h0);

    // Randomized traffic, biased toward low indices so bypass hits are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, r1, r2, ds;
      wr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
      ds = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        model_clear();
        #1;
        rst = 1'b0;
      end
      cycle(1'($urandom_range(0, 1)), wr, $urandom, r1, r2, ds);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
